// File: rtl/ddr_cmd_ctrl.sv
// Closed-page DRAM command controller: power-up init, single-beat read/write
// accesses (ACT -> RD/WR -> PRE) and periodic auto-refresh.
module ddr_cmd_ctrl #(
  parameter int BANK_BITS   = 3,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int T_RCD       = 2,
  parameter int CL          = 2,
  parameter int T_WR        = 2,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 4,
  parameter int T_REFI      = 64,
  parameter int INIT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BANK_BITS-1:0]  req_bank,
  input  logic [ADDR_WIDTH-1:0] req_row,
  input  logic [ADDR_WIDTH-1:0] req_col,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wmask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [BANK_BITS-1:0]  ba,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dq_out,
  output logic                  dq_oe,
  input  logic [DATA_WIDTH-1:0] dq_in,
  output logic                  dqs_out,
  output logic                  dqs_oe,
  output logic                  dm
);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT_CKE  = 4'd1,
    S_INIT_PRE  = 4'd2,
    S_INIT_MRS  = 4'd3,
    S_IDLE      = 4'd4,
    S_ACT       = 4'd5,
    S_RW        = 4'd6,
    S_WDATA     = 4'd7,
    S_RWAIT     = 4'd8,
    S_PRE       = 4'd9,
    S_REF       = 4'd10
  } state_t;

  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [ADDR_WIDTH-1:0] PRE_ALL = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] MRS_VAL = ADDR_WIDTH'((CL & 7) << 4);

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] RCD_LAST  = 16'(T_RCD - 1);
  localparam logic [15:0] CL_LAST   = 16'(CL - 1);
  localparam logic [15:0] WR_LAST   = 16'(T_WR - 1);
  localparam logic [15:0] RP_LAST   = 16'(T_RP - 1);
  localparam logic [15:0] RFC_LAST  = 16'(T_RFC - 1);
  localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

  state_t                state_r;
  logic [15:0]           cnt_r;
  logic [15:0]           refi_r;
  logic                  ref_pending_r;
  logic [3:0]            cmd_r;
  logic                  we_r;
  logic [BANK_BITS-1:0]  bank_r;
  logic [ADDR_WIDTH-1:0] col_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  wmask_r;

  assign {cs_n, ras_n, cas_n, we_n} = cmd_r;
  assign req_ready = (state_r == S_IDLE) && !ref_pending_r;

  // Sequencer: every pin is a register loaded one cycle ahead of its bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_INIT_WAIT;
      cnt_r         <= 16'd0;
      refi_r        <= 16'd0;
      ref_pending_r <= 1'b0;
      cmd_r         <= CMD_DES;
      cke           <= 1'b0;
      ba            <= '0;
      addr          <= '0;
      dq_out        <= '0;
      dq_oe         <= 1'b0;
      dqs_out       <= 1'b0;
      dqs_oe        <= 1'b0;
      dm            <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      init_done     <= 1'b0;
      we_r          <= 1'b0;
      bank_r        <= '0;
      col_r         <= '0;
      wdata_r       <= '0;
      wmask_r       <= 1'b0;
    end else begin
      cmd_r     <= CMD_NOP;
      ba        <= '0;
      addr      <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      dqs_out   <= 1'b0;
      dqs_oe    <= 1'b0;
      dm        <= 1'b0;
      rsp_valid <= 1'b0;
      cnt_r     <= cnt_r + 16'd1;

      // Refresh interval timer; a wrap with the flag already set is absorbed.
      if (init_done) begin
        if (refi_r == REFI_LAST) begin
          refi_r        <= 16'd0;
          ref_pending_r <= 1'b1;
        end else begin
          refi_r <= refi_r + 16'd1;
        end
      end else begin
        refi_r <= 16'd0;
      end

      case (state_r)
        S_INIT_WAIT: begin
          if (cnt_r == INIT_LAST) begin
            cke     <= 1'b1;
            state_r <= S_INIT_CKE;
            cnt_r   <= 16'd0;
          end else begin
            cmd_r <= CMD_DES;
          end
        end
        S_INIT_CKE: begin
          cmd_r   <= CMD_PRE;
          addr    <= PRE_ALL;
          state_r <= S_INIT_PRE;
          cnt_r   <= 16'd0;
        end
        S_INIT_PRE: begin
          if (cnt_r == RP_LAST) begin
            cmd_r   <= CMD_MRS;
            addr    <= MRS_VAL;
            state_r <= S_INIT_MRS;
            cnt_r   <= 16'd0;
          end
        end
        S_INIT_MRS: begin
          if (cnt_r == 16'd1) begin
            init_done <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        S_IDLE: begin
          // A request accepted on the same edge that raises ref_pending goes first.
          if (req_valid && req_ready) begin
            we_r    <= req_we;
            bank_r  <= req_bank;
            col_r   <= req_col;
            wdata_r <= req_wdata;
            wmask_r <= req_wmask;
            cmd_r   <= CMD_ACT;
            ba      <= req_bank;
            addr    <= req_row;
            state_r <= S_ACT;
            cnt_r   <= 16'd0;
          end else if (ref_pending_r) begin
            cmd_r         <= CMD_REF;
            ref_pending_r <= 1'b0;
            state_r       <= S_REF;
            cnt_r         <= 16'd0;
          end
        end
        S_ACT: begin
          if (cnt_r == RCD_LAST) begin
            cmd_r   <= we_r ? CMD_WR : CMD_RD;
            ba      <= bank_r;
            addr    <= col_r;
            state_r <= S_RW;
            cnt_r   <= 16'd0;
          end
        end
        S_RW: begin
          if (we_r) begin
            dq_out  <= wdata_r;
            dq_oe   <= 1'b1;
            dqs_out <= 1'b1;
            dqs_oe  <= 1'b1;
            dm      <= wmask_r;
            state_r <= S_WDATA;
          end else begin
            state_r <= S_RWAIT;
          end
          cnt_r <= 16'd0;
        end
        S_WDATA: begin
          if (cnt_r == WR_LAST) begin
            cmd_r   <= CMD_PRE;
            ba      <= bank_r;
            state_r <= S_PRE;
            cnt_r   <= 16'd0;
          end
        end
        S_RWAIT: begin
          if (cnt_r == CL_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= dq_in;
            cmd_r     <= CMD_PRE;
            ba        <= bank_r;
            state_r   <= S_PRE;
            cnt_r     <= 16'd0;
          end
        end
        S_PRE: begin
          if (cnt_r == RP_LAST) begin
            state_r <= S_IDLE;
          end
        end
        S_REF: begin
          if (cnt_r == RFC_LAST) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          cke       <= 1'b0;
          init_done <= 1'b0;
          cmd_r     <= CMD_DES;
          state_r   <= S_INIT_WAIT;
          cnt_r     <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_ctrl.sv
// Directed bench for ddr_cmd_ctrl with a small behavioural DRAM and a
// read-response scoreboard.
module tb_ddr_cmd_ctrl;

  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_bank = 3'd0;
  logic [7:0] req_row = 8'h00;
  logic [7:0] req_col = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_wmask = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0] ba;
  logic [7:0] addr;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic [7:0] dq_in = 8'h3C;
  logic       dqs_out, dqs_oe, dm;

  ddr_cmd_ctrl #(
    .BANK_BITS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8), .T_RCD(2), .CL(2), .T_WR(2),
    .T_RP(2), .T_RFC(4), .T_REFI(64), .INIT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .init_done(init_done), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in), .dqs_out(dqs_out),
    .dqs_oe(dqs_oe), .dm(dm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [int];
  logic [7:0] dram_mem [int];
  logic [7:0] open_row [8];
  int         rd_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  int         wr_key = 0;

  int cyc = 0;
  int d_cyc = 0;
  bit d_valid = 1'b0;
  int wrap_cyc = 0;
  bit wrap_valid = 1'b0;
  bit ref_seen = 1'b0;
  int nop_left = 0;
  bit bank_open = 1'b0;
  int ref_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [2:0] b, input logic [7:0] r, input logic [7:0] c);
    return int'({b, r, c});
  endfunction

  function automatic logic [30:0] pins_obs();
    return {cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_oe, dqs_oe, dqs_out,
            dq_out, dm, rsp_valid, req_ready, init_done};
  endfunction

  function automatic logic [30:0] pins_exp(input logic k, input logic [3:0] c,
      input logic [2:0] b, input logic [7:0] a, input logic oe, input logic [7:0] d,
      input logic m, input logic rv, input logic rdy, input logic idn);
    return {k, c, b, a, oe, oe, oe, d, m, rv, rdy, idn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DRAM model: read data appears on dq_in during the CL-th cycle after RD.
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
      dq_in  = 8'h3C;
    end else begin
      dq_in = 8'h3C;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) dq_in = rd_data;
      end
      if (dq_oe && dqs_oe && !dm) dram_mem[wr_key] = dq_out;
      case ({cs_n, ras_n, cas_n, we_n})
        C_ACT: open_row[ba] = addr;
        C_RD: begin
          rd_cnt  = 2;
          rd_data = dram_mem.exists(key(ba, open_row[ba], addr)) ?
                    dram_mem[key(ba, open_row[ba], addr)] : 8'h00;
        end
        C_WR: wr_key = key(ba, open_row[ba], addr);
        default: ;
      endcase
    end
  end

  // Pin monitor: refresh placement and read-response scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      d_valid    = 1'b0;
      wrap_valid = 1'b0;
      nop_left   = 0;
      bank_open  = 1'b0;
    end else begin
      if (init_done && !d_valid) begin
        d_valid = 1'b1;
        d_cyc   = cyc;
      end
      if (d_valid && cyc != d_cyc && ((cyc - d_cyc) % 64) == 0) begin
        wrap_valid = 1'b1;
        wrap_cyc   = cyc;
        ref_seen   = 1'b0;
      end
      if (nop_left > 0) begin
        chk("NOP after REF", {cs_n, ras_n, cas_n, we_n}, C_NOP);
        nop_left--;
      end
      if ({cs_n, ras_n, cas_n, we_n} == C_REF) begin
        chk("REF window", wrap_valid && (cyc - wrap_cyc >= 1) && (cyc - wrap_cyc <= 8), 1);
        chk("REF with bank open", bank_open, 0);
        ref_seen = 1'b1;
        nop_left = 4;
        ref_cnt++;
      end
      if ({cs_n, ras_n, cas_n, we_n} == C_ACT) bank_open = 1'b1;
      if ({cs_n, ras_n, cas_n, we_n} == C_PRE && init_done) bank_open = 1'b0;
      if (wrap_valid && cyc == wrap_cyc + 9) chk("REF issued after wrap", ref_seen, 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected rsp_valid", 1, 0);
        else chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic check_init();
    logic [3:0] c;
    logic [7:0] a;
    for (int k = 0; k <= 21; k++) begin
      c = (k < 16) ? C_DES : (k == 17) ? C_PRE : (k == 19) ? C_MRS : C_NOP;
      a = (k == 17) ? 8'h80 : (k == 19) ? 8'h20 : 8'h00;
      chk($sformatf("init cycle %0d", k), pins_obs(),
          pins_exp(k >= 16, c, 3'd0, a, 1'b0, 8'h00, 1'b0, 1'b0, k >= 21, k >= 21));
      if (k < 21) tick();
    end
  endtask

  task automatic access(input logic we, input logic [2:0] b, input logic [7:0] r,
      input logic [7:0] co, input logic [7:0] d, input logic m);
    int w;
    logic [7:0] rexp;
    logic [3:0] c;
    logic [2:0] bb;
    logic [7:0] aa, dd;
    logic oe, mm, rv;
    req_we = we; req_bank = b; req_row = r; req_col = co; req_wdata = d; req_wmask = m;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 30) begin
      tick();
      w++;
    end
    chk("req_ready wait", req_ready, 1);
    rexp = ref_mem.exists(key(b, r, co)) ? ref_mem[key(b, r, co)] : 8'h00;
    if (we) begin
      if (!m) ref_mem[key(b, r, co)] = d;
    end else begin
      exp_q.push_back(rexp);
    end
    tick();
    req_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      c = C_NOP; bb = 3'd0; aa = 8'h00; oe = 1'b0; dd = 8'h00; mm = 1'b0; rv = 1'b0;
      if (j == 1) begin
        c = C_ACT; bb = b; aa = r;
      end else if (j == 3) begin
        c = we ? C_WR : C_RD; bb = b; aa = co;
      end else if (j == 6) begin
        c = C_PRE; bb = b; rv = !we;
      end
      if (we && j == 4) begin
        oe = 1'b1; dd = d; mm = m;
      end
      chk($sformatf("%s n+%0d", we ? "write" : "read", j), pins_obs(),
          pins_exp(1'b1, c, bb, aa, oe, dd, mm, rv, j == 8, 1'b1));
      if (!we && j == 8) chk("rsp_rdata hold", rsp_rdata, rexp);
      if (j < 8) tick();
    end
  endtask

  initial begin
    int hs;
    int ref_before;
    int w;
    repeat (3) tick();
    rst = 1'b0;
    check_init();

    access(1'b1, 3'd3, 8'h12, 8'h05, 8'hA5, 1'b0);
    access(1'b0, 3'd3, 8'h12, 8'h05, 8'h00, 1'b0);

    // Abort a write in its WR cycle; init must restart from scratch.
    req_we = 1'b1; req_bank = 3'd5; req_row = 8'h33; req_col = 8'h44;
    req_wdata = 8'h77; req_wmask = 1'b0; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 30) begin
      tick();
      w++;
    end
    chk("abort ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("abort WR cycle", {cs_n, ras_n, cas_n, we_n}, C_WR);
    rst = 1'b1;
    tick();
    chk("abort reset values", pins_obs(),
        pins_exp(1'b0, C_DES, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    check_init();

    access(1'b1, 3'd1, 8'h40, 8'h07, 8'h5A, 1'b0);
    access(1'b0, 3'd1, 8'h40, 8'h07, 8'h00, 1'b0);
    access(1'b1, 3'd1, 8'h40, 8'h07, 8'hFF, 1'b1);
    access(1'b0, 3'd1, 8'h40, 8'h07, 8'h00, 1'b0);

    // Saturated request stream across several refresh intervals.
    hs = 0;
    ref_before = ref_cnt;
    req_we = 1'b1; req_bank = 3'd2; req_row = 8'h66; req_col = 8'h09;
    req_wdata = 8'h11; req_wmask = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (req_ready) begin
        if (req_we) ref_mem[key(3'd2, 8'h66, 8'h09)] = req_wdata;
        else exp_q.push_back(ref_mem[key(3'd2, 8'h66, 8'h09)]);
        hs++;
        tick();
        req_we = !req_we;
        if (req_we) req_wdata = req_wdata + 8'h13;
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
    repeat (12) tick();
    chk("stream handshakes", hs >= 18, 1);
    chk("stream refreshes", (ref_cnt - ref_before) >= 3, 1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_ctrl.md
# ddr_cmd_ctrl

Closed-page DRAM command controller sitting directly upstream of the `dram` simulation model. It accepts single-beat read/write requests on a valid/ready interface and runs the power-up init sequence. It issues ACT, RD/WR and PRE with parameterised timing gaps, schedules periodic auto-refresh, and drives/captures the data pins. The testbench top connects its pin outputs to `dram` and merges the split dq/dqs buses into the inout pins.

## Interface
- BANK_BITS, 3, bank address width
- ADDR_WIDTH, 8, row/column address width; also DRAM `addr` width
- DATA_WIDTH, 8, data beat width
- T_RCD, 2, cycles from ACT to RD/WR
- CL, 2, read latency in cycles from RD to data valid on dq_in
- T_WR, 2, cycles from write data beat to PRE
- T_RP, 2, cycles from PRE to next command
- T_RFC, 4, cycles from REF to next command
- T_REFI, 64, refresh interval in cycles
- INIT_CYCLES, 16, cycles cke is held low after reset
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = write, 0 = read
- req_bank  in  BANK_BITS  target bank
- req_row  in  ADDR_WIDTH  row address
- req_col  in  ADDR_WIDTH  column address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  1  1 = mask the write (drives dm)
- rsp_valid  out  1  one-cycle pulse: rsp_rdata is valid
- rsp_rdata  out  DATA_WIDTH  read data; holds its value until the next read
- init_done  out  1  init sequence complete; stays high until rst
- cke, cs_n, ras_n, cas_n, we_n  out  1 each  DRAM control pins, all registered
- ba  out  BANK_BITS  bank pins
- addr  out  ADDR_WIDTH  address pins
- dq_out, dq_oe  out  DATA_WIDTH, 1  write data and its output enable
- dq_in  in  DATA_WIDTH  dq as seen from the pins
- dqs_out, dqs_oe  out  1, 1  strobe and its output enable
- dm  out  1  data mask

## Operation
- The command is the tuple {cs_n, ras_n, cas_n, we_n}:
  - NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000.
  - Every cycle that has no listed command drives NOP with ba = 0 and addr = 0.
- Reset values: cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, addr=0, dq_out=0, dq_oe=0, dqs_out=0, dqs_oe=0, dm=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- States: INIT_WAIT → INIT_CKE → INIT_PRE → INIT_MRS → IDLE. From IDLE: ACT → RW → (WDATA | RWAIT) → PRE → IDLE, or REF → IDLE.
- Init sequence, with cycle 0 = first cycle after rst deasserts:
  - cycles 0..INIT_CYCLES-1: cke=0, cs_n=1.
  - cycle INIT_CYCLES: cke=1, NOP.
  - cycle INIT_CYCLES+1: PRE-all (addr[ADDR_WIDTH-1]=1).
  - cycle INIT_CYCLES+1+T_RP: MRS with ba=0, addr[6:4]=CL, all other addr bits 0.
  - cycle INIT_CYCLES+3+T_RP: init_done=1 and enter IDLE.
- req_ready = (state==IDLE) && !ref_pending. It is combinational from registered state.
- Closed-page policy: every access is ACT, RD/WR, then PRE to the same bank. No bank is left open in IDLE.
- Refresh:
  - refi counter starts at 0 when init_done rises, wraps at T_REFI-1, and sets ref_pending on each wrap.
  - In IDLE with ref_pending: issue REF next cycle, clear ref_pending, wait T_RFC, return to IDLE.
  - Refresh never preempts an access in flight.
  - A wrap while ref_pending is already set is absorbed; the flag saturates.
  - If the handshake and the ref_pending set occur at the same edge, the request wins and the refresh follows it.
- rst at any time aborts the current access or refresh on the next edge. All outputs return to their reset values and init restarts; no PRE is issued for an aborted access.

## Timing
Cycle n = edge where the handshake occurs.
- Both directions:
  - n+1: ACT, ba=req_bank, addr=req_row. The request fields are latched at n.
  - n+1+T_RCD: WR or RD, ba=bank, addr=col.
- Write:
  - n+2+T_RCD: one data beat with dq_oe=dqs_oe=1, dqs_out=1, dq_out=wdata, dm=wmask. All are 0 in every other cycle.
  - n+2+T_RCD+T_WR: PRE.
- Read:
  - dq_in is sampled at the end of cycle n+1+T_RCD+CL.
  - n+2+T_RCD+CL: rsp_valid=1 with rsp_rdata, and PRE in the same cycle.
- req_ready rises T_RP cycles after the PRE cycle. With defaults both write and read give PRE at n+6 and req_ready at n+8.
- Back-to-back accepted requests are therefore 8 cycles apart at defaults.

## Test plan
- Init: release rst → cke=0 for 16 cycles; PRE-all at cycle 17 with addr=8'h80; MRS at 19 with addr=8'h20; init_done=1 and req_ready=1 at 21.
- Write bank 3, row 8'h12, col 8'h05, data 8'hA5, mask 0 → ACT n+1 (ba=3, addr=12), WR n+3 (addr=05), dq_oe/dqs_oe high with dq_out=A5 at n+4, PRE n+6, req_ready at n+8.
- Read after the write with the model returning 8'hA5 → RD n+3, rsp_valid pulse at n+6 with rsp_rdata=A5, PRE n+6, exactly one pulse.
- Hold req_valid continuously for 200 cycles → a REF appears within at most 8 cycles of each 64-cycle refi wrap; no REF overlaps ACT–PRE; REF is followed by ≥4 NOP cycles.
- Assert rst at n+3 (the WR cycle) → on the next edge cke=0, dq_oe=0, req_ready=0, init_done=0, and the init sequence repeats exactly.
- Masked write (wmask=1) → dm=1 only during the data beat; a subsequent read of the same address returns the old data.
